pkt_buf_writer: RTL and testbench

PKT_BUF_WRITER -- requirements
Module: pkt_buf_writer

---
 rtl/pkt_buf_writer.sv | 137 +++++++++++++
 tb/tb_pkt_buf_writer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_buf_writer.sv
// Writes received Ethernet frames byte-by-byte into a flat packet buffer and
// rings a one-cycle doorbell for frames with the expected EtherType and length.
module pkt_buf_writer #(
    parameter int          ETH_MTU   = 1518,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          MIN_LEN   = 22
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        rx_valid_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_last_in,
    input  logic        rx_err_in,
    output logic [7:0]  pkt_buf_out [ETH_MTU],
    output logic        pkt_buf_doorbell_out,
    output logic [10:0] pkt_len_out,
    output logic [15:0] accept_count_out,
    output logic [15:0] drop_count_out
);
    // The index must be able to reach ETH_MTU to detect oversize frames.
    localparam int IDX_W = $clog2(ETH_MTU + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       buf_q [ETH_MTU];
    logic             doorbell_q;
    logic [10:0]      len_q;
    logic [15:0]      accept_q;
    logic [15:0]      drop_q;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             full;
    logic [15:0]      etype;
    logic             etype_ok;
    logic             len_ok;

    always_comb begin
        full     = (int'(idx_q) == ETH_MTU);
        // Byte 13 may be on the bus right now, so bypass it into the compare.
        etype    = {buf_q[12], (int'(idx_q) == 13) ? rx_data_in : buf_q[13]};
        etype_ok = (int'(idx_q) >= 13) && (etype == ETHERTYPE);
        len_ok   = ((int'(idx_q) + 1) >= MIN_LEN);
        wr_en    = 1'b0;
        wr_idx   = idx_q;
        if (rx_valid_in && !rx_err_in) begin
            if (state_q == IDLE) begin
                wr_en  = 1'b1;
                wr_idx = '0;
            end else if (state_q == RECV && !full) begin
                wr_en  = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < ETH_MTU; gi++) begin : g_entry
        always_ff @(posedge clock_in) begin
            if (reset_in) begin
                buf_q[gi] <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                buf_q[gi] <= rx_data_in;
            end
        end
        assign pkt_buf_out[gi] = buf_q[gi];
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            doorbell_q <= 1'b0;
            len_q      <= '0;
            accept_q   <= '0;
            drop_q     <= '0;
        end else begin
            doorbell_q <= 1'b0;
            if (rx_valid_in) begin
                unique case (state_q)
                    IDLE: begin
                        if (rx_last_in) begin
                            drop_q <= drop_q + 16'd1;
                        end else if (rx_err_in) begin
                            state_q <= DROP;
                        end else begin
                            idx_q   <= IDX_W'(1);
                            state_q <= RECV;
                        end
                    end
                    RECV: begin
                        if (rx_err_in || full) begin
                            // A bad byte that also ends the frame closes it out here.
                            if (rx_last_in) begin
                                drop_q  <= drop_q + 16'd1;
                                state_q <= IDLE;
                            end else begin
                                state_q <= DROP;
                            end
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            if (rx_last_in) begin
                                state_q <= IDLE;
                                if (len_ok && etype_ok) begin
                                    doorbell_q <= 1'b1;
                                    len_q      <= 11'(int'(idx_q) + 1);
                                    accept_q   <= accept_q + 16'd1;
                                end else begin
                                    drop_q <= drop_q + 16'd1;
                                end
                            end else if ((int'(idx_q) == 13) && !etype_ok) begin
                                state_q <= DROP;
                            end
                        end
                    end
                    DROP: begin
                        if (rx_last_in) begin
                            drop_q  <= drop_q + 16'd1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pkt_buf_doorbell_out = doorbell_q;
    assign pkt_len_out          = len_q;
    assign accept_count_out     = accept_q;
    assign drop_count_out       = drop_q;

endmodule

// File: tb/tb_pkt_buf_writer.sv
// Directed bench for pkt_buf_writer: a per-cycle vector table for the frame
// scenarios, then hand-written oversize, mid-frame reset and counter-wrap runs.
module tb_pkt_buf_writer;
    localparam int MTU = 1518;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_last = 1'b0;
    logic        rx_err = 1'b0;
    logic [7:0]  pkt_buf [MTU];
    logic        doorbell;
    logic [10:0] pkt_len;
    logic [15:0] acc_cnt;
    logic [15:0] drop_cnt;

    pkt_buf_writer dut (
        .clock_in             (clk),
        .reset_in             (rst),
        .rx_valid_in          (rx_valid),
        .rx_data_in           (rx_data),
        .rx_last_in           (rx_last),
        .rx_err_in            (rx_err),
        .pkt_buf_out          (pkt_buf),
        .pkt_buf_doorbell_out (doorbell),
        .pkt_len_out          (pkt_len),
        .accept_count_out     (acc_cnt),
        .drop_count_out       (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic        last;
        logic        err;
        logic [7:0]  data;
        logic        wr;
        logic [10:0] wr_idx;
        logic        exp_db;
        logic [10:0] exp_len;
        logic [15:0] exp_acc;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t        vq [$];
    logic [7:0]  exp_buf [MTU];
    int          checks = 0;
    int          errors = 0;
    int          b_acc = 0;
    int          b_drop = 0;
    logic [10:0] b_len = '0;

    function automatic logic [7:0] pat(input int i, input int seed, input logic [15:0] et);
        if (i == 12) return et[15:8];
        if (i == 13) return et[7:0];
        return 8'(i * 7 + seed);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_buf(input string name, input int n);
        int bad = -1;
        for (int i = 0; i < n; i++)
            if (pkt_buf[i] !== exp_buf[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: entry %0d got %0h expected %0h", name, bad, pkt_buf[bad], exp_buf[bad]);
        end
    endtask

    task automatic chk_pat(input string name, input int n, input int off, input int seed,
                           input logic [15:0] et);
        int bad = -1;
        for (int j = 0; j < n; j++)
            if (pkt_buf[j] !== pat(j + off, seed, et) && bad < 0) bad = j;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: entry %0d got %0h expected %0h", name, bad, pkt_buf[bad],
                     pat(bad + off, seed, et));
        end
    endtask

    task automatic push(input logic r, input logic v, input logic l, input logic e,
                        input logic [7:0] d, input logic w, input int wi, input logic db);
        vec_t t;
        t.rst = r; t.valid = v; t.last = l; t.err = e; t.data = d;
        t.wr = w; t.wr_idx = 11'(wi); t.exp_db = db;
        t.exp_len = b_len; t.exp_acc = 16'(b_acc); t.exp_drop = 16'(b_drop);
        vq.push_back(t);
    endtask

    task automatic add_idle(input int n);
        repeat (n) push(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    endtask

    task automatic add_reset(input int n);
        b_acc = 0; b_drop = 0; b_len = '0;
        repeat (n) push(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    endtask

    // good: the hand-determined verdict; wr_n: how many leading bytes land in the buffer.
    task automatic add_frame(input int len, input logic [15:0] et, input int seed,
                             input int gap_at, input int gap_n, input int err_at,
                             input int wr_n, input bit good);
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) add_idle(gap_n);
            if (i == len - 1) begin
                if (good) begin b_acc++; b_len = 11'(len); end
                else b_drop++;
            end
            push(1'b0, 1'b1, (i == len - 1), (i == err_at), pat(i, seed, et),
                 (i < wr_n), i, (good && (i == len - 1)));
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic e,
                        input logic r);
        rx_valid = v; rx_data = d; rx_last = l; rx_err = e; rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit any_db;
        int nz;

        add_reset(2);
        add_idle(2);
        add_frame(22, 16'h88B5, 1, -1, 0, -1, 22, 1'b1);     // minimal good frame
        add_idle(2);
        add_frame(22, 16'h88B5, 1, 10, 3, -1, 22, 1'b1);     // same frame, 3-cycle stall
        add_frame(60, 16'h0800, 5, -1, 0, -1, 14, 1'b0);     // wrong EtherType
        add_idle(1);
        add_frame(64, 16'h88B5, 9, -1, 0, 30, 30, 1'b0);     // error on byte 30
        add_frame(22, 16'h88B5, 3, -1, 0, -1, 22, 1'b1);     // back-to-back good frame
        add_frame(30, 16'h88B5, 11, -1, 0, -1, 30, 1'b1);
        add_frame(25, 16'h88B5, 13, -1, 0, -1, 25, 1'b1);    // starts on the doorbell cycle
        add_frame(1, 16'h88B5, 15, -1, 0, -1, 1, 1'b0);      // single-byte frame
        add_frame(21, 16'h88B5, 17, -1, 0, -1, 21, 1'b0);    // one byte short of MIN_LEN
        add_frame(1518, 16'h88B5, 29, -1, 0, -1, 1518, 1'b1); // exactly the buffer depth
        add_idle(2);

        foreach (vq[k]) begin
            rst = vq[k].rst; rx_valid = vq[k].valid; rx_last = vq[k].last;
            rx_err = vq[k].err; rx_data = vq[k].data;
            @(posedge clk);
            #1;
            if (vq[k].rst) begin
                for (int i = 0; i < MTU; i++) exp_buf[i] = 8'h00;
            end else if (vq[k].wr) begin
                exp_buf[vq[k].wr_idx] = vq[k].data;
            end
            chk($sformatf("doorbell[v%0d]", k), 32'(doorbell), 32'(vq[k].exp_db));
            chk($sformatf("pkt_len[v%0d]", k), 32'(pkt_len), 32'(vq[k].exp_len));
            chk($sformatf("accept_count[v%0d]", k), 32'(acc_cnt), 32'(vq[k].exp_acc));
            chk($sformatf("drop_count[v%0d]", k), 32'(drop_cnt), 32'(vq[k].exp_drop));
            if (vq[k].rst) chk_buf($sformatf("reset_buf[v%0d]", k), MTU);
            if (vq[k].exp_db) chk_buf($sformatf("frame_buf[v%0d]", k), int'(vq[k].exp_len));
            if (vq[k].valid && vq[k].last)
                $display("frame end v%0d: doorbell=%0b len=%0d accepts=%0d drops=%0d",
                         k, doorbell, pkt_len, acc_cnt, drop_cnt);
        end

        // Oversize: 1519 bytes with a good EtherType.
        any_db = 1'b0;
        for (int i = 0; i < 1519; i++) begin
            step(1'b1, pat(i, 31, 16'h88B5), (i == 1518), 1'b0, 1'b0);
            any_db |= doorbell;
        end
        chk("oversize_no_doorbell", 32'(any_db), 32'd0);
        chk("oversize_drop", 32'(drop_cnt), 32'd5);
        chk("oversize_accept", 32'(acc_cnt), 32'd6);
        chk("oversize_entry1517", 32'(pkt_buf[1517]), 32'(pat(1517, 31, 16'h88B5)));
        $display("oversize frame: accepts=%0d drops=%0d entry1517=%0h", acc_cnt, drop_cnt, pkt_buf[1517]);

        // Reset asserted while byte 10 of a frame is on the bus.
        for (int i = 0; i < 10; i++) step(1'b1, pat(i, 21, 16'h88B5), 1'b0, 1'b0, 1'b0);
        step(1'b1, pat(10, 21, 16'h88B5), 1'b0, 1'b0, 1'b1);
        nz = 0;
        for (int i = 0; i < MTU; i++) if (pkt_buf[i] !== 8'h00) nz++;
        chk("midreset_buf_zero", 32'(nz), 32'd0);
        chk("midreset_doorbell", 32'(doorbell), 32'd0);
        chk("midreset_len", 32'(pkt_len), 32'd0);
        chk("midreset_accept", 32'(acc_cnt), 32'd0);
        chk("midreset_drop", 32'(drop_cnt), 32'd0);
        any_db = 1'b0;
        for (int i = 11; i < 22; i++) begin
            step(1'b1, pat(i, 21, 16'h88B5), (i == 21), 1'b0, 1'b0);
            any_db |= doorbell;
        end
        chk("residual_no_doorbell", 32'(any_db), 32'd0);
        chk("residual_drop", 32'(drop_cnt), 32'd1);
        chk("residual_accept", 32'(acc_cnt), 32'd0);
        chk_pat("residual_buf", 11, 11, 21, 16'h88B5);
        chk("residual_entry11", 32'(pkt_buf[11]), 32'd0);
        $display("mid-frame reset: residual tail dropped, drops=%0d", drop_cnt);

        for (int i = 0; i < 22; i++) step(1'b1, pat(i, 23, 16'h88B5), (i == 21), 1'b0, 1'b0);
        chk("post_reset_doorbell", 32'(doorbell), 32'd1);
        chk("post_reset_len", 32'(pkt_len), 32'd22);
        chk("post_reset_accept", 32'(acc_cnt), 32'd1);
        chk_pat("post_reset_buf", 22, 0, 23, 16'h88B5);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("post_reset_pulse_end", 32'(doorbell), 32'd0);
        $display("post-reset frame: len=%0d accepts=%0d", pkt_len, acc_cnt);

        // 65535 single-byte drops take the drop counter from 1 through FFFF to 0.
        any_db = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
            any_db |= doorbell;
        end
        chk("wrap_drop", 32'(drop_cnt), 32'd0);
        chk("wrap_accept", 32'(acc_cnt), 32'd1);
        chk("wrap_no_doorbell", 32'(any_db), 32'd0);
        $display("drop counter wrap: drops=%0d", drop_cnt);

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
